bus_store_arbiter_n: RTL and testbench

//  N-master arbiter for the shared AXI store (write) path; successor to the 2-master store arbiter.

---
 rtl/bus_arb_pkg.sv | 12 +
 rtl/arb_rr_picker.sv | 58 +++++
 rtl/bus_store_arbiter_n.sv | 100 ++++++++++
 tb/tb_bus_store_arbiter_n.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiters: policy encodings and the FSM state type.
package bus_arb_pkg;

  localparam int unsigned ARB_MODE_FIXED = 0;
  localparam int unsigned ARB_MODE_RR    = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational winner selection from a request vector.
// Fixed priority takes the lowest index; round-robin scans upward from last_owner+1.
module arb_rr_picker
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MODE        = ARB_MODE_FIXED,
  localparam int unsigned IDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_owner,
  output logic [IDX_W-1:0]       winner,
  output logic                   valid
);

  // One extra bit holds start+offset, which can reach 2*NUM_MASTERS-1 before the wrap.
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [2*NUM_MASTERS-1:0] dbl;
  logic [SUM_W-1:0]         start;
  logic [SUM_W-1:0]         offset;
  logic [SUM_W-1:0]         sum;
  logic                     found;

  always_comb begin
    valid  = |req;
    winner = '0;
    dbl    = '0;
    start  = '0;
    offset = '0;
    sum    = '0;
    found  = 1'b0;
    if (MODE == ARB_MODE_RR) begin
      // Duplicating req lets a linear scan from start cover the wrapped order without a modulo per bit.
      dbl   = {req, req};
      start = SUM_W'(last_owner) + SUM_W'(1);
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!found && dbl[start + SUM_W'(i)]) begin
          found  = 1'b1;
          offset = SUM_W'(i);
        end
      end
      sum = start + offset;
      if (sum >= SUM_W'(NUM_MASTERS)) begin
        sum = sum - SUM_W'(NUM_MASTERS);
      end
      winner = sum[IDX_W-1:0];
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!found && req[i]) begin
          found  = 1'b1;
          winner = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/bus_store_arbiter_n.sv
// N-master arbiter for the shared AXI write path: grants one master per write transaction,
// holds it until the B handshake, with optional grant parking and a hang watchdog.
module bus_store_arbiter_n
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MODE        = ARB_MODE_FIXED,
  parameter int unsigned PARK        = 1,
  parameter int unsigned TIMEOUT     = 0,
  localparam int unsigned IDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   xfer_done,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

  arb_state_t       state;
  logic [IDX_W-1:0] last_owner;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             wd_fire;

  arb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .MODE        (MODE)
  ) u_picker (
    .req        (req),
    .last_owner (last_owner),
    .winner     (pick_idx),
    .valid      (pick_valid)
  );

  if (TIMEOUT > 0) begin : g_wd
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (state == IDLE) begin
        cnt <= '0;
      end else if (!xfer_done && cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    // A completion in the same cycle takes precedence over the forced release.
    assign wd_fire = (state == BUSY) && !xfer_done && (cnt == CNT_W'(TIMEOUT - 1));
  end else begin : g_no_wd
    assign wd_fire = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_owner  <= '0;
      grant       <= (PARK != 0) ? ONE : '0;
      grant_idx   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= BUSY;
            busy       <= 1'b1;
            grant      <= ONE << pick_idx;
            grant_idx  <= pick_idx;
            last_owner <= pick_idx;
          end else begin
            grant <= (PARK != 0) ? (ONE << last_owner) : '0;
          end
        end
        BUSY: begin
          if (xfer_done || wd_fire) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= wd_fire;
            if (PARK == 0) begin
              grant <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_store_arbiter_n.sv
// Directed bench for bus_store_arbiter_n across fixed, round-robin, watchdog and no-park builds.
module tb_bus_store_arbiter_n;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0] req_f, req_r, req_w, req_n;
  logic       done_f, done_r, done_w, done_n;
  logic [3:0] g_f, g_r, g_w, g_n;
  logic [1:0] idx_f, idx_r, idx_w, idx_n;
  logic       b_f, b_r, b_w, b_n;
  logic       te_f, te_r, te_w, te_n;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  bus_store_arbiter_n #(.NUM_MASTERS(4), .MODE(0), .PARK(1), .TIMEOUT(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req_f), .xfer_done(done_f),
    .grant(g_f), .grant_idx(idx_f), .busy(b_f), .timeout_err(te_f));

  bus_store_arbiter_n #(.NUM_MASTERS(4), .MODE(1), .PARK(1), .TIMEOUT(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_r), .xfer_done(done_r),
    .grant(g_r), .grant_idx(idx_r), .busy(b_r), .timeout_err(te_r));

  bus_store_arbiter_n #(.NUM_MASTERS(4), .MODE(0), .PARK(1), .TIMEOUT(8)) u_wd (
    .clk(clk), .rst_n(rst_n), .req(req_w), .xfer_done(done_w),
    .grant(g_w), .grant_idx(idx_w), .busy(b_w), .timeout_err(te_w));

  bus_store_arbiter_n #(.NUM_MASTERS(4), .MODE(0), .PARK(0), .TIMEOUT(0)) u_np (
    .clk(clk), .rst_n(rst_n), .req(req_n), .xfer_done(done_n),
    .grant(g_n), .grant_idx(idx_n), .busy(b_n), .timeout_err(te_n));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Invariants sampled on the falling edge, away from the active edge.
  logic [3:0] pg [4];
  logic       pb [4];

  task automatic inv(input string nm, input int k, input logic [3:0] g, input logic [1:0] idx,
                     input logic b, input bit no_park);
    chk({nm, "_onehot0"}, 32'($onehot0(g)), 32'd1);
    if (b) chk({nm, "_busy_has_grant"}, 32'(g != 4'd0), 32'd1);
    if (g != 4'd0) chk({nm, "_idx_matches"}, 32'(g[idx]), 32'd1);
    if (b && pb[k]) chk({nm, "_busy_stable"}, 32'(g), 32'(pg[k]));
    if (no_park && !b) chk({nm, "_idle_no_grant"}, 32'(g), 32'd0);
    pg[k] = g;
    pb[k] = b;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      inv("fix", 0, g_f, idx_f, b_f, 1'b0);
      inv("rr",  1, g_r, idx_r, b_r, 1'b0);
      inv("wd",  2, g_w, idx_w, b_w, 1'b0);
      inv("np",  3, g_n, idx_n, b_n, 1'b1);
    end
  end

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic [1:0] idx;
    logic       busy;
  } vec_t;

  vec_t vt[16];

  initial begin
    // Fixed-priority, parked build; expected values are the outputs after the following edge.
    vt[0]  = '{4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0};
    vt[1]  = '{4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0};
    vt[2]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
    vt[3]  = '{4'b1011, 1'b0, 4'b0010, 2'd1, 1'b1};
    vt[4]  = '{4'b1011, 1'b0, 4'b0010, 2'd1, 1'b1};
    vt[5]  = '{4'b1011, 1'b1, 4'b0010, 2'd1, 1'b0};
    vt[6]  = '{4'b1011, 1'b0, 4'b0001, 2'd0, 1'b1};
    vt[7]  = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0};
    vt[8]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
    vt[9]  = '{4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};
    vt[10] = '{4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};
    vt[11] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
    vt[12] = '{4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0};
    vt[13] = '{4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0};
    vt[14] = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1};
    vt[15] = '{4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0};

    rst_n = 1'b0;
    req_f = '0; req_r = '0; req_w = '0; req_n = '0;
    done_f = 1'b0; done_r = 1'b0; done_w = 1'b0; done_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pg[k] = '0;
      pb[k] = 1'b0;
    end
    repeat (3) step();

    chk("rst_fix_grant", 32'(g_f), 32'h1);
    chk("rst_fix_idx", 32'(idx_f), 32'h0);
    chk("rst_fix_busy", 32'(b_f), 32'h0);
    chk("rst_fix_terr", 32'(te_f), 32'h0);
    chk("rst_np_grant", 32'(g_n), 32'h0);
    chk("rst_wd_terr", 32'(te_w), 32'h0);
    mon_en = 1'b1;
    rst_n  = 1'b1;

    for (int i = 0; i < 16; i++) begin
      req_f  = vt[i].req;
      done_f = vt[i].done;
      step();
      chk($sformatf("vec%0d_grant", i), 32'(g_f), 32'(vt[i].g));
      chk($sformatf("vec%0d_idx", i), 32'(idx_f), 32'(vt[i].idx));
      chk($sformatf("vec%0d_busy", i), 32'(b_f), 32'(vt[i].busy));
    end
    req_f = '0;
    done_f = 1'b0;

    // Round-robin with every master requesting: order rotates from last_owner=0.
    begin
      logic [1:0] order[5];
      order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0; order[4] = 2'd1;
      req_r = 4'b1111;
      for (int t = 0; t < 5; t++) begin
        int n;
        n = 0;
        do begin
          step();
          n++;
        end while (!b_r && n < 4);
        chk($sformatf("rr%0d_granted", t), 32'(b_r), 32'd1);
        chk($sformatf("rr%0d_grant", t), 32'(g_r), 32'(4'b0001 << order[t]));
        chk($sformatf("rr%0d_idx", t), 32'(idx_r), 32'(order[t]));
        step();
        step();
        done_r = 1'b1;
        step();
        done_r = 1'b0;
        chk($sformatf("rr%0d_bubble", t), 32'(b_r), 32'd0);
      end
      // last_owner is now 1; as sole requester it still wins.
      req_r = 4'b0010;
      step();
      chk("rr_sole_grant", 32'(g_r), 32'h2);
      chk("rr_sole_busy", 32'(b_r), 32'd1);
      req_r = '0;
      done_r = 1'b1;
      step();
      done_r = 1'b0;
      chk("rr_sole_release", 32'(b_r), 32'd0);
    end

    // Watchdog: no completion, forced release after 8 busy cycles.
    req_w = 4'b0001;
    step();
    chk("wd_grant", 32'(g_w), 32'h1);
    chk("wd_busy", 32'(b_w), 32'd1);
    req_w = '0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("wd_hold%0d_busy", i), 32'(b_w), 32'd1);
      chk($sformatf("wd_hold%0d_terr", i), 32'(te_w), 32'd0);
    end
    step();
    chk("wd_release_busy", 32'(b_w), 32'd0);
    chk("wd_release_terr", 32'(te_w), 32'd1);
    step();
    chk("wd_terr_pulse_end", 32'(te_w), 32'd0);

    // Completion on the watchdog cycle itself: normal release, no error.
    req_w = 4'b0001;
    step();
    chk("wd2_busy", 32'(b_w), 32'd1);
    req_w = '0;
    repeat (7) step();
    chk("wd2_still_busy", 32'(b_w), 32'd1);
    done_w = 1'b1;
    step();
    done_w = 1'b0;
    chk("wd2_release_busy", 32'(b_w), 32'd0);
    chk("wd2_release_terr", 32'(te_w), 32'd0);
    step();
    chk("wd2_terr_quiet", 32'(te_w), 32'd0);

    // Owner drops req mid-transaction; no-park build releases to zero.
    req_n = 4'b0100;
    step();
    chk("drop_grant", 32'(g_n), 32'h4);
    req_n = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("drop_hold%0d", i), 32'(g_n), 32'h4);
    end
    done_n = 1'b1;
    step();
    done_n = 1'b0;
    chk("drop_release_grant", 32'(g_n), 32'h0);
    chk("drop_release_busy", 32'(b_n), 32'd0);
    chk("drop_release_idx", 32'(idx_n), 32'd2);

    // Reset while busy, then xfer_done in idle must be ignored.
    req_n = 4'b0100;
    step();
    chk("rstbusy_pre", 32'(b_n), 32'd1);
    req_n = '0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstbusy_grant", 32'(g_n), 32'h0);
    chk("rstbusy_busy", 32'(b_n), 32'd0);
    chk("rstbusy_idx", 32'(idx_n), 32'd0);
    done_n = 1'b1;
    step();
    done_n = 1'b0;
    chk("idle_done_grant", 32'(g_n), 32'h0);
    chk("idle_done_busy", 32'(b_n), 32'd0);
    step();
    chk("idle_done_terr", 32'(te_n), 32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
